// File: rtl/surf_trig_tx_if.sv
//------------------------------------------------------------------------------
// Module  : surf_trig_tx_if
// Brief   : Trigger request stream (valid/ready) into the SURF trigger transmitter.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface surf_trig_tx_if;
    logic [19:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/surf_trig_tx.sv
//------------------------------------------------------------------------------
// Module  : surf_trig_tx
// Brief   : Queues trigger requests and serializes each as header+meta words on
//           4-clock slots aligned to the 8-clock command cycle.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module surf_trig_tx #(
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [15:0] TRAIN_PATTERN = 16'h6A5C
) (
    input  logic             sysclk_i,
    input  logic             sysclk_rst_n_i,
    input  logic             sysclk_phase_i,
    input  logic             enable_i,
    input  logic             train_i,
    surf_trig_tx_if.slave    s_trig,
    output logic [15:0]      trig_dat_o,
    output logic             trig_dat_valid_o,
    output logic [15:0]      trig_count_o,
    output logic [6:0]       fifo_count_o
);

    localparam int         c_AW    = $clog2(FIFO_DEPTH);
    localparam logic [6:0] c_DEPTH = 7'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_META = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_cnt;
    logic            r_locked;
    logic            r_alive;
    logic [19:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [6:0]      r_fifo_count;
    logic [7:0]      r_meta;
    logic [15:0]     r_dat;
    logic [15:0]     r_trig_count;

    logic            w_slot;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic [19:0]     w_head;
    logic [15:0]     w_dat_nxt;

    assign w_empty        = (r_fifo_count == 7'd0);
    assign w_full         = (r_fifo_count == c_DEPTH);
    assign w_head         = r_mem[r_rd_ptr];
    // r_alive keeps tready low while reset is held and for the release edge.
    assign s_trig.tready  = r_alive && !w_full;
    assign w_push         = s_trig.tvalid && r_alive && !w_full;
    assign w_slot         = sysclk_phase_i || (r_locked && (r_cnt == 3'd4));

    assign trig_dat_o       = r_dat;
    assign trig_dat_valid_o = r_locked;
    assign trig_count_o     = r_trig_count;
    assign fifo_count_o     = r_fifo_count;

    always_comb begin
        w_state_nxt = r_state;
        w_dat_nxt   = r_dat;
        w_pop       = 1'b0;
        if (w_slot) begin
            case (r_state)
                ST_IDLE: begin
                    if (train_i) begin
                        w_dat_nxt = TRAIN_PATTERN;
                    end else if (enable_i && !w_empty) begin
                        w_pop       = 1'b1;
                        w_dat_nxt   = {1'b1, 3'b000, w_head[11:0]};
                        w_state_nxt = ST_META;
                    end else begin
                        w_dat_nxt = 16'h0000;
                    end
                end
                ST_META: begin
                    // Metadata always follows its header, whatever train/enable do.
                    w_dat_nxt   = {8'h00, r_meta};
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rst_n_i) begin
        if (!sysclk_rst_n_i) begin
            r_state      <= ST_IDLE;
            r_dat        <= 16'h0000;
            r_meta       <= 8'h00;
            r_trig_count <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_dat   <= w_dat_nxt;
            if (w_pop) begin
                r_meta       <= w_head[19:12];
                r_trig_count <= r_trig_count + 16'd1;
            end
        end
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rst_n_i) begin
        if (!sysclk_rst_n_i) begin
            r_cnt    <= 3'd0;
            r_locked <= 1'b0;
            r_alive  <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (sysclk_phase_i) begin
                r_cnt    <= 3'd1;
                r_locked <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rst_n_i) begin
        if (!sysclk_rst_n_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= 7'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 7'd1;
                2'b01:   r_fifo_count <= r_fifo_count - 7'd1;
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_trig.tdata;
        end
    end

endmodule

`default_nettype wire
